// File: rtl/fpadd_rr_scheduler.sv
// fpadd_rr_scheduler
//
// Purpose:
//   Shares one pipelined 16-bit FP adder between two requesters using
//   round-robin arbitration. The adder has two internal registers
//   (align->calc and calc->norm), so the result appears combinationally
//   at fa_s two enabled clock edges after the operands are presented.
//   This block drives the adder operands and enable, tracks in-flight
//   operations in a 2-deep tag pipeline that mirrors the adder registers,
//   and returns results on a valid/ready channel tagged with the
//   requester id and the requester's opaque tag. Backpressure on the
//   result channel stalls the whole adder through fa_e.
//
// Ports:
//   clk, clrn                 clock (rising edge), async active-low reset
//                             (shared with the adder)
//   req_valid/req_ready [1:0] per-requester handshake, bit i = requester i
//   req_a, req_b [31:0]       {req1, req0} fp16 operands
//   req_sub [1:0]             per-requester subtract flag
//   req_rm [3:0]              {req1 rm, req0 rm}, 2 bits each
//   req_tag [2*TAG_W-1:0]     per-requester opaque tag
//   flush                     synchronous discard of all in-flight ops
//   fa_a, fa_b, fa_sub, fa_rm adder operand/control inputs
//   fa_e                      adder pipeline enable
//   fa_s                      adder result
//   res_valid/res_ready       result channel handshake
//   res_data, res_id, res_tag result value, issuing requester, its tag
//   busy                      any operation in flight
//
// Optional feature (macro FPADD_SCHED_STATS_EN):
//   Adds saturating 16-bit counters stat_issued0, stat_issued1 (issues per
//   requester) and stat_stall (cycles with fa_e=0). They clear only on
//   clrn, never on flush.

module fpadd_rr_scheduler #(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [31:0]        req_a,
    input  logic [31:0]        req_b,
    input  logic [1:0]         req_sub,
    input  logic [3:0]         req_rm,
    input  logic [2*TAG_W-1:0] req_tag,
    input  logic               flush,
    output logic [15:0]        fa_a,
    output logic [15:0]        fa_b,
    output logic               fa_sub,
    output logic [1:0]         fa_rm,
    output logic               fa_e,
    input  logic [15:0]        fa_s,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [15:0]        res_data,
    output logic               res_id,
    output logic [TAG_W-1:0]   res_tag,
`ifdef FPADD_SCHED_STATS_EN
    output logic [15:0]        stat_issued0,
    output logic [15:0]        stat_issued1,
    output logic [15:0]        stat_stall,
`endif
    output logic               busy
);

    // Tag pipeline: stage 1 mirrors the adder align->calc register,
    // stage 2 mirrors the calc->norm register.
    logic             v1, v2;
    logic             id1, id2;
    logic [TAG_W-1:0] tag1, tag2;
    logic             rr;

    logic             can_grant;
    logic [1:0]       grant;
    logic             issue;
    logic             grant_id;
    logic [TAG_W-1:0] grant_tag;

    // The adder only stalls when a finished result is waiting and the
    // consumer refuses it.
    assign fa_e = !(v2 && !res_ready);

    // Grants are also withheld while clrn is low so that req_ready reads
    // zero during reset even if requesters are already asserting valid.
    assign can_grant = fa_e && !flush && clrn;

    // Round-robin arbitration: on contention the requester that was not
    // granted last wins; rr resets to 1 so requester 0 wins first.
    always_comb begin
        grant = 2'b00;
        if (can_grant) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign issue     = |(req_valid & grant);
    assign grant_id  = grant[1];

    // Operand mux towards the adder; everything is zero when nobody is
    // granted so the adder never sees stale operands.
    always_comb begin
        fa_a      = 16'h0000;
        fa_b      = 16'h0000;
        fa_sub    = 1'b0;
        fa_rm     = 2'b00;
        grant_tag = '0;
        if (grant[0]) begin
            fa_a      = req_a[15:0];
            fa_b      = req_b[15:0];
            fa_sub    = req_sub[0];
            fa_rm     = req_rm[1:0];
            grant_tag = req_tag[TAG_W-1:0];
        end else if (grant[1]) begin
            fa_a      = req_a[31:16];
            fa_b      = req_b[31:16];
            fa_sub    = req_sub[1];
            fa_rm     = req_rm[3:2];
            grant_tag = req_tag[2*TAG_W-1:TAG_W];
        end
    end

    // Flush overrides a stall: both valid bits clear even if fa_e=0. The
    // id/tag registers are left alone since they are meaningless without
    // their valid bits. No grant happens in a flush cycle, so rr holds.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            id1  <= 1'b0;
            id2  <= 1'b0;
            tag1 <= '0;
            tag2 <= '0;
            rr   <= 1'b1;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (fa_e) begin
            v2   <= v1;
            id2  <= id1;
            tag2 <= tag1;
            v1   <= issue;
            id1  <= grant_id;
            tag1 <= grant_tag;
            if (issue) begin
                rr <= grant_id;
            end
        end
    end

    assign res_valid = v2;
    assign res_data  = fa_s;
    assign res_id    = id2;
    assign res_tag   = tag2;
    assign busy      = v1 | v2;

`ifdef FPADD_SCHED_STATS_EN
    // Saturating counters; flush does not clear them.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stat_issued0 <= 16'h0000;
            stat_issued1 <= 16'h0000;
            stat_stall   <= 16'h0000;
        end else begin
            if (issue && !grant_id && stat_issued0 != 16'hFFFF) begin
                stat_issued0 <= stat_issued0 + 16'd1;
            end
            if (issue && grant_id && stat_issued1 != 16'hFFFF) begin
                stat_issued1 <= stat_issued1 + 16'd1;
            end
            if (!fa_e && stat_stall != 16'hFFFF) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule
